chip_7458_tester: RTL and testbench
===================================

CHIP_7458_TESTER -- requirements
Module: chip_7458_tester

Interface
REQ-001 Parameter SETTLE_CYC, default 2: cycles to wait after applying a vector before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  single-cycle request to begin a full exhaustive run.
REQ-005 abort  input  1  request to terminate a run in progress.
REQ-006 dut_in  output  10  vector driven to the device under test; bit0..5 = p1a..p1f, bit6..9 = p2a..p2d.
REQ-007 dut_y  input  2  device outputs; bit0 = p1y, bit1 = p2y.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high after a run completes normally; held until the next accepted start.
REQ-010 pass  output  1  valid when done is high; 1 iff err_cnt == 0.
REQ-011 err_cnt  output  11  count of failing vectors in the current or last run.
REQ-012 first_fail_valid  output  1  high once any vector has failed in the current or last run.
REQ-013 first_fail_vec  output  10  index of the first failing vector; valid when first_fail_valid is high.

Function
REQ-014 FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-015 IDLE or DONE with start=1: clear vec_idx, err_cnt and first_fail_valid; clear done; go to APPLY.
REQ-016 APPLY, one cycle: drive dut_in = vec_idx; load the settle counter with SETTLE_CYC; go to SETTLE.
REQ-017 SETTLE: decrement the settle counter each cycle; after SETTLE_CYC cycles, go to CHECK.
REQ-018 CHECK, one cycle: compare dut_y with the golden result for vec_idx. Golden p1y = (p1a&p1b&p1c)|(p1d&p1e&p1f). Golden p2y = (p2a&p2b)|(p2c&p2d).
REQ-019 A vector fails when either output bit mismatches; each failing vector adds exactly 1 to err_cnt.
REQ-020 On the first failure of a run: capture first_fail_vec = vec_idx and set first_fail_valid. Later failures do not overwrite it.
REQ-021 CHECK with vec_idx < 1023: increment vec_idx and go to APPLY.
REQ-022 CHECK with vec_idx == 1023: go to DONE and set done; vec_idx does not wrap within a run.
REQ-023 Each vector takes SETTLE_CYC+2 cycles. A full run takes 1024*(SETTLE_CYC+2) cycles from the first APPLY to entry into DONE.
REQ-024 dut_in holds its value from APPLY through CHECK. In IDLE and DONE it holds the last applied vector (0 after reset).
REQ-025 busy = 1 in APPLY, SETTLE and CHECK; busy = 0 otherwise.
REQ-026 start while busy is ignored.
REQ-027 abort while busy returns the FSM to IDLE on the next edge. done stays 0; err_cnt and first_fail_* keep their current values.
REQ-028 abort has priority over a CHECK-cycle update: the vector checked in that cycle is not counted.
REQ-029 abort and start asserted together in IDLE or DONE: start wins and the run begins.
REQ-030 err_cnt is 11 bits and never overflows (maximum 1024).

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, dut_in = 0, vec_idx = 0, settle counter = 0, err_cnt = 0, first_fail_vec = 0, first_fail_valid = 0, busy = 0, done = 0, pass = 0.
REQ-032 Reset asserted mid-run discards the run; after rst_n rises, the block waits in IDLE for start.

Structure
REQ-033 Shared package chip_7458_pkg holds:
  - FSM state enum
  - VEC_W = 10
  - NUM_VEC = 1024
  - ERR_W = 11
  - dut_in bit-position constants
REQ-034 The golden model is one instance of the existing chip_7458 combinational module, fed from vec_idx. No other sub-modules.

Verification
REQ-035 Correct chip_7458 on dut_y, SETTLE_CYC=2, single start -> busy for 4096 cycles; then done=1, pass=1, err_cnt=0, first_fail_valid=0.
REQ-036 p2y stuck-at-0 -> done=1, pass=0, err_cnt=448, first_fail_vec=192 (10'b0011000000).
REQ-037 p1y stuck-at-1 -> err_cnt=784, first_fail_vec=0.
REQ-038 abort pulsed at cycle 100 of a run -> IDLE next edge, busy=0, done=0; a following start completes normally with pass=1.
REQ-039 start pulsed at cycle 50 while busy -> ignored; done still asserts at cycle 4096 with unchanged results.
REQ-040 rst_n low at cycle 2000 (asynchronous, mid-cycle) -> all outputs 0 immediately; no activity until the next start.

Source files
------------

// File: rtl/chip_7458_pkg.sv
// Shared types and constants for the 7458 exhaustive tester.
package chip_7458_pkg;

  localparam int VEC_W   = 10;
  localparam int NUM_VEC = 1024;
  localparam int ERR_W   = 11;

  // Bit positions of each device pin within dut_in / vec_idx
  localparam int P1A = 0;
  localparam int P1B = 1;
  localparam int P1C = 2;
  localparam int P1D = 3;
  localparam int P1E = 4;
  localparam int P1F = 5;
  localparam int P2A = 6;
  localparam int P2B = 7;
  localparam int P2C = 8;
  localparam int P2D = 9;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/chip_7458.sv
// Behavioural 7458: dual AND-OR gate, used as the golden reference.
module chip_7458 (
  input  logic p1a,
  input  logic p1b,
  input  logic p1c,
  input  logic p1d,
  input  logic p1e,
  input  logic p1f,
  input  logic p2a,
  input  logic p2b,
  input  logic p2c,
  input  logic p2d,
  output logic p1y,
  output logic p2y
);

  assign p1y = (p1a & p1b & p1c) | (p1d & p1e & p1f);
  assign p2y = (p2a & p2b) | (p2c & p2d);

endmodule

// File: rtl/chip_7458_tester.sv
// Exhaustive 1024-vector tester for a 7458: applies each vector, waits
// SETTLE_CYC cycles, compares against the golden model and logs failures.
module chip_7458_tester
  import chip_7458_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [VEC_W-1:0] dut_in,
  input  logic [1:0]       dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  state_t           state, nxt;
  logic [VEC_W-1:0] vec_idx;
  logic [3:0]       settle_cnt;
  logic             gold_p1y, gold_p2y;
  logic             mismatch;
  logic             run_go;
  logic             chk_en;

  chip_7458 u_gold (
    .p1a (vec_idx[P1A]),
    .p1b (vec_idx[P1B]),
    .p1c (vec_idx[P1C]),
    .p1d (vec_idx[P1D]),
    .p1e (vec_idx[P1E]),
    .p1f (vec_idx[P1F]),
    .p2a (vec_idx[P2A]),
    .p2b (vec_idx[P2B]),
    .p2c (vec_idx[P2C]),
    .p2d (vec_idx[P2D]),
    .p1y (gold_p1y),
    .p2y (gold_p2y)
  );

  assign mismatch = (dut_y != {gold_p2y, gold_p1y});
  assign busy     = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_CHECK);
  assign pass     = done && (err_cnt == '0);
  // start is only honoured when idle or finished; it beats a concurrent abort there
  assign run_go   = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  // an abort in the CHECK cycle suppresses that vector's result
  assign chk_en   = (state == ST_CHECK) && !abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Next-state logic; abort anywhere in a run drops back to IDLE
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE,
      ST_DONE:   if (start) nxt = ST_APPLY;
      ST_APPLY:  nxt = abort ? ST_IDLE : ST_SETTLE;
      ST_SETTLE: if (abort)                  nxt = ST_IDLE;
                 else if (settle_cnt == 4'd1) nxt = ST_CHECK;
      ST_CHECK:  if (abort)                  nxt = ST_IDLE;
                 else if (vec_idx == LAST_VEC) nxt = ST_DONE;
                 else                         nxt = ST_APPLY;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Datapath: vector index, drive register, settle timer and result capture.
  // dut_in is loaded on entry to APPLY so it equals vec_idx for the whole vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in           <= '0;
      vec_idx          <= '0;
      settle_cnt       <= '0;
      err_cnt          <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      done             <= 1'b0;
    end else begin
      if (run_go) begin
        vec_idx          <= '0;
        dut_in           <= '0;
        err_cnt          <= '0;
        first_fail_valid <= 1'b0;
        done             <= 1'b0;
      end
      if (state == ST_APPLY)  settle_cnt <= SETTLE_LD;
      if (state == ST_SETTLE) settle_cnt <= settle_cnt - 4'd1;
      if (chk_en) begin
        if (mismatch) begin
          err_cnt <= err_cnt + ERR_W'(1);
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= vec_idx;
          end
        end
        if (vec_idx == LAST_VEC) begin
          done <= 1'b1;
        end else begin
          vec_idx <= vec_idx + VEC_W'(1);
          dut_in  <= vec_idx + VEC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_chip_7458_tester.sv
// Self-checking bench: emulated 7458 with selectable faults, scoreboard of
// expected run results, plus abort / restart / reset scenarios.
module tb_chip_7458_tester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [9:0]  dut_in;
  logic [1:0]  dut_y;
  logic        busy, done, pass;
  logic [10:0] err_cnt;
  logic        first_fail_valid;
  logic [9:0]  first_fail_vec;

  int fault_mode = 0;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int errs;
    int ffv;
    int ffvec;
  } exp_t;

  exp_t sb[$];

  chip_7458_tester #(.SETTLE_CYC(2)) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .dut_in           (dut_in),
    .dut_y            (dut_y),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_cnt          (err_cnt),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_y(input logic [9:0] v);
    logic p1, p2;
    p1 = (v[0] & v[1] & v[2]) | (v[3] & v[4] & v[5]);
    p2 = (v[6] & v[7]) | (v[8] & v[9]);
    return {p2, p1};
  endfunction

  // Device emulation: 0 good, 1 p2y sa0, 2 p1y sa1, 3 bad last vector, 4 two bad vectors
  function automatic logic [1:0] dev_y(input logic [9:0] v, input int mode);
    logic [1:0] y;
    y = ref_y(v);
    case (mode)
      1: y[1] = 1'b0;
      2: y[0] = 1'b1;
      3: if (v == 10'd1023) y[0] = ~y[0];
      4: if (v == 10'd5 || v == 10'd700) y[1] = ~y[1];
      default: ;
    endcase
    return y;
  endfunction

  always_comb dut_y = dev_y(dut_in, fault_mode);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push_exp(input int mode);
    exp_t e;
    e.errs = 0; e.ffv = 0; e.ffvec = 0;
    for (int v = 0; v < 1024; v++) begin
      if (dev_y(10'(v), mode) != ref_y(10'(v))) begin
        if (e.ffv == 0) begin e.ffv = 1; e.ffvec = v; end
        e.errs++;
      end
    end
    sb.push_back(e);
  endtask

  task automatic run_full(input int mode, input bit mid_start, input bit with_abort);
    int   cnt;
    exp_t e;
    fault_mode = mode;
    push_exp(mode);
    @(negedge clk); start = 1'b1; abort = with_abort;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("run_begin_busy", busy, 1);
    chk("run_clr_done", done, 0);
    chk("run_clr_err", err_cnt, 0);
    chk("run_clr_ffv", first_fail_valid, 0);
    cnt = 0;
    while (!done && cnt < 10000) begin
      if (busy) cnt++;
      if (cnt == 1001) chk("dut_in_mid", dut_in, 250);
      start = (mid_start && cnt == 50);
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", cnt, 4096);
    chk("done", done, 1);
    chk("busy_after_done", busy, 0);
    chk("dut_in_hold", dut_in, 1023);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("err_cnt", err_cnt, e.errs);
      chk("pass", pass, (e.errs == 0));
      chk("ffv", first_fail_valid, e.ffv);
      if (e.ffv != 0) chk("ffvec", first_fail_vec, e.ffvec);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_dut_in", dut_in, 0);
    chk("rst_ffv", first_fail_valid, 0);
    chk("rst_ffvec", first_fail_vec, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);

    run_full(0, 0, 0);            // good device
    run_full(1, 0, 0);            // p2y stuck-at-0: 448 errors, first 192
    run_full(2, 0, 1);            // p1y stuck-at-1, abort+start together in DONE
    run_full(3, 1, 0);            // only last vector bad; start ignored mid-run
    run_full(4, 0, 0);            // two isolated failures, first must not move

    // abort at cycle 100 of a run
    fault_mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (99) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    chk("abort_stay_idle", busy, 0);
    run_full(0, 0, 0);

    // abort coinciding with the CHECK of vector 0 (which would fail)
    fault_mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;   // APPLY
    @(negedge clk);                 // SETTLE
    @(negedge clk);                 // SETTLE
    @(negedge clk); abort = 1'b1;   // CHECK
    @(negedge clk); abort = 1'b0;
    chk("chk_abort_busy", busy, 0);
    chk("chk_abort_err", err_cnt, 0);
    chk("chk_abort_ffv", first_fail_valid, 0);

    // asynchronous reset mid-run
    fault_mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2000) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_err", err_cnt, 0);
    chk("mrst_dut_in", dut_in, 0);
    chk("mrst_ffv", first_fail_valid, 0);
    chk("mrst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_dut_in", dut_in, 0);
    chk("post_rst_done", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
